// File: rtl/fwd_pkg.sv
// fwd_pkg: forward-select codes and register constants shared by the hazard unit
package fwd_pkg;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_RSVD  = 2'b11;
  localparam logic [4:0] REG_ZERO  = 5'd0;
endpackage

// File: rtl/fwd_compare.sv
// fwd_compare: per-operand producer match, youngest producer (EX) wins over MEM
module fwd_compare
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              uses_src,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic              mem_we,
  output logic [1:0]        sel
);
  logic hit_e, hit_m;
  assign hit_e = uses_src & ex_we & (ex_dest != REG_AW'(REG_ZERO)) & (ex_dest == src);
  assign hit_m = uses_src & mem_we & (mem_dest != REG_AW'(REG_ZERO)) & (mem_dest == src);
  assign sel = hit_e ? FWD_EXMEM : hit_m ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: dest pipe tracking, registered forward selects, load-use stall and stall counter
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_reg_write,
  output logic [REG_AW-1:0] wb_dest,
  output logic              wb_reg_write,
  output logic [CNT_W-1:0]  stall_count
);
  logic [REG_AW-1:0] mem_dest_q, wb_dest_q;
  logic              mem_we_q, wb_we_q, hazard;
  logic [1:0]        a_cmp, b_cmp, a_d, b_d, a_q, b_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  fwd_compare #(.REG_AW(REG_AW)) u_cmp_a (
    .src(id_rs), .uses_src(id_uses_rs), .ex_dest(ex_dest), .ex_we(ex_reg_write),
    .mem_dest(mem_dest_q), .mem_we(mem_we_q), .sel(a_cmp)
  );
  fwd_compare #(.REG_AW(REG_AW)) u_cmp_b (
    .src(id_rt), .uses_src(id_uses_rt), .ex_dest(ex_dest), .ex_we(ex_reg_write),
    .mem_dest(mem_dest_q), .mem_we(mem_we_q), .sel(b_cmp)
  );

  assign hazard = ex_mem_read & ex_reg_write & (ex_dest != REG_AW'(REG_ZERO)) &
                  ((id_uses_rs & (ex_dest == id_rs)) | (id_uses_rt & (ex_dest == id_rt)));
  assign stall  = rst_n & hazard;

  // bubble or flush sends zero selects into EX; only unflushed stalls are counted, saturating
  always_comb begin
    a_d   = (flush | hazard) ? FWD_RF : a_cmp;
    b_d   = (flush | hazard) ? FWD_RF : b_cmp;
    cnt_d = (hazard & ~flush & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // dest pipe advances every edge, even while stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_dest_q <= '0;
      mem_we_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_we_q    <= 1'b0;
      a_q        <= FWD_RF;
      b_q        <= FWD_RF;
      cnt_q      <= '0;
    end else begin
      mem_dest_q <= ex_dest;
      mem_we_q   <= ex_reg_write;
      wb_dest_q  <= mem_dest_q;
      wb_we_q    <= mem_we_q;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign fwd_a_sel     = a_q;
  assign fwd_b_sel     = b_q;
  assign mem_dest      = mem_dest_q;
  assign mem_reg_write = mem_we_q;
  assign wb_dest       = wb_dest_q;
  assign wb_reg_write  = wb_we_q;
  assign stall_count   = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: randomized and directed checks against a behavioural pipeline model
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read, flush;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, mem_reg_write, wb_reg_write;
  logic [4:0] mem_dest, wb_dest;
  logic [15:0] stall_count;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .flush(flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .mem_dest(mem_dest), .mem_reg_write(mem_reg_write), .wb_dest(wb_dest),
    .wb_reg_write(wb_reg_write), .stall_count(stall_count)
  );

  int tests = 0, fails = 0;
  // model state: the instruction history one and two stages behind EX, plus selects and count
  int m_md = 0, m_wd = 0, m_mw = 0, m_ww = 0, m_a = 0, m_b = 0, m_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int m_stall();
    if (!rst_n || !ex_mem_read || !ex_reg_write || ex_dest == 0) return 0;
    return ((id_uses_rs && ex_dest == id_rs) || (id_uses_rt && ex_dest == id_rt)) ? 1 : 0;
  endfunction

  function automatic int m_sel(input int src, input int uses);
    if (!uses) return 0;
    if (ex_reg_write && ex_dest != 0 && ex_dest == src) return 1;
    if (m_mw != 0 && m_md != 0 && m_md == src) return 2;
    return 0;
  endfunction

  task automatic set(input int rs, input int rt, input int urs, input int urt,
                     input int ed, input int ew, input int emr, input int fl);
    id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs[0]; id_uses_rt = urt[0];
    ex_dest = 5'(ed); ex_reg_write = ew[0]; ex_mem_read = emr[0]; flush = fl[0];
  endtask

  // one cycle: check the combinational stall, advance the model, clock, check registered outputs
  task automatic step();
    int st, na, nb;
    #1;
    st = m_stall();
    chk("stall", int'(stall), st);
    na = (flush || st != 0) ? 0 : m_sel(id_rs, id_uses_rs);
    nb = (flush || st != 0) ? 0 : m_sel(id_rt, id_uses_rt);
    if (!rst_n) begin
      m_md = 0; m_mw = 0; m_wd = 0; m_ww = 0; m_a = 0; m_b = 0; m_cnt = 0;
    end else begin
      m_wd = m_md; m_ww = m_mw; m_md = ex_dest; m_mw = ex_reg_write;
      m_a = na; m_b = nb;
      if (st != 0 && !flush && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    chk("fwd_a_sel", int'(fwd_a_sel), m_a);
    chk("fwd_b_sel", int'(fwd_b_sel), m_b);
    chk("mem_dest", int'(mem_dest), m_md);
    chk("mem_reg_write", int'(mem_reg_write), m_mw);
    chk("wb_dest", int'(wb_dest), m_wd);
    chk("wb_reg_write", int'(wb_reg_write), m_ww);
    chk("stall_count", int'(stall_count), m_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("reset_a", int'(fwd_a_sel), 0);
    chk("reset_cnt", int'(stall_count), 0);
    rst_n = 1'b1;
    set(5, 0, 1, 0, 5, 1, 0, 0); step();
    chk("t1_a", int'(fwd_a_sel), 1);
    chk("t1_b", int'(fwd_b_sel), 0);
    set(0, 7, 0, 1, 7, 1, 0, 0); step();
    set(0, 7, 0, 1, 7, 1, 0, 0); step();
    chk("t2_ex_prio", int'(fwd_b_sel), 1);
    set(0, 7, 0, 1, 7, 0, 0, 0); step();
    chk("t2_mem", int'(fwd_b_sel), 2);
    set(9, 0, 1, 0, 9, 1, 1, 0); #1;
    chk("t3_stall", int'(stall), 1);
    step();
    chk("t3_bubble", int'(fwd_a_sel), 0);
    chk("t3_cnt", int'(stall_count), 1);
    set(9, 0, 1, 0, 3, 0, 0, 0); #1;
    chk("t3_retry_stall", int'(stall), 0);
    step();
    chk("t3_retry_a", int'(fwd_a_sel), 2);
    set(0, 0, 1, 1, 0, 1, 0, 0); step();
    chk("t4_r0", int'(fwd_a_sel), 0);
    set(0, 0, 1, 1, 0, 1, 1, 0); #1;
    chk("t4_load_r0", int'(stall), 0);
    step();
    set(4, 4, 1, 1, 4, 1, 0, 0); step();
    chk("rs_eq_rt_a", int'(fwd_a_sel), 1);
    chk("rs_eq_rt_b", int'(fwd_b_sel), 1);
    set(6, 0, 1, 0, 6, 1, 1, 1); step();
    chk("flush_sel", int'(fwd_a_sel), 0);
    chk("flush_cnt", int'(stall_count), 1);
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      set($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 9) == 0) ? 1 : 0);
      step();
    end
    rst_n = 1'b1;
    set(8, 0, 1, 0, 8, 1, 1, 0);
    for (int i = 0; i < 65539; i++) step();
    chk("t5_saturate", int'(stall_count), 65535);
    set(8, 0, 1, 0, 8, 1, 1, 1); step();
    chk("t5_flush_sel", int'(fwd_a_sel), 0);
    chk("t5_flush_cnt", int'(stall_count), 65535);
    set(8, 0, 1, 0, 8, 1, 1, 0);
    rst_n = 1'b0; #1;
    chk("t6_stall_in_reset", int'(stall), 0);
    step();
    chk("t6_cnt", int'(stall_count), 0);
    chk("t6_mem", int'(mem_dest), 0);
    rst_n = 1'b1;
    set(0, 0, 0, 0, 12, 1, 0, 0); step();
    chk("t6_mem12", int'(mem_dest), 12);
    set(0, 0, 0, 0, 13, 1, 0, 0); step();
    chk("t6_mem13", int'(mem_dest), 13);
    chk("t6_wb12", int'(wb_dest), 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
